dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data memory between two requesters: m0 = core load/store port, m1 = debug/loader port.
//  Sits between the requesters and the data memory; drives MemRead/MemWrite/address/write_data.
//  Round-robin arbitration with a bounded hold, so neither requester can starve the other.
//  One memory access per granted cycle; read data is returned registered, one cycle later.
// PARAMETERS
//  ADDR_W    32  address width (word index into data memory)
//  DATA_W    32  data width
//  MAX_HOLD  4   max consecutive grants to one owner while the other requests (>=1)
// PORTS
//  clk         in   1       clock, all state on rising edge
//  rst         in   1       synchronous reset, active-high
//  m0_req      in   1       m0 access request, held until m0_gnt
//  m0_we       in   1       m0 write(1)/read(0), valid with m0_req
//  m0_addr     in   ADDR_W  m0 address
//  m0_wdata    in   DATA_W  m0 write data
//  m0_gnt      out  1       m0 access performed this cycle
//  m0_rvalid   out  1       m0 read data valid (1-cycle pulse)
//  m0_rdata    out  DATA_W  m0 read data, held until next m0 read response
//  m1_*        --   --      identical set for requester m1
//  mem_read    out  1       to data memory MemRead
//  mem_write   out  1       to data memory MemWrite
//  mem_addr    out  ADDR_W  to data memory address
//  mem_wdata   out  DATA_W  to data memory write_data
//  mem_rdata   in   DATA_W  from data memory read_data (combinational read)
//  owner       out  2       current FSM state: 00 IDLE, 01 OWN0, 10 OWN1
// BEHAVIOUR
//  Reset: state IDLE, rr_last=1 (m0 favoured first), hold_cnt=0, m*_rvalid=0, m*_rdata=0.
//   Reset applied mid-access overrides everything: no rvalid pulse is issued for the aborted cycle.
//  Grant logic: combinational from state + reqs. At most one gnt per cycle; no gnt without req.
//  The granted port's we/addr/wdata drive mem_*: mem_read=gnt&~we, mem_write=gnt&we.
//   With no grant: mem_* = 0.
//  The memory write commits on the grant edge.
//   Read: mem_rdata is captured into mX_rdata on the grant edge; mX_rvalid=1 the following cycle only.
//  FSM, evaluated each cycle:
//   IDLE: no req -> no gnt, stay IDLE.
//    One req -> grant it and go to OWNx with hold_cnt=1.
//    Both req -> grant the port != rr_last.
//   OWNx, req_x=1, and (req_y=0 or hold_cnt<MAX_HOLD) -> grant x, hold_cnt++ (saturating at MAX_HOLD).
//   OWNx, req_x=1, req_y=1, hold_cnt==MAX_HOLD -> grant y, go to OWNy, hold_cnt=1.
//   OWNx, req_x=0, req_y=1 -> grant y same cycle, go to OWNy, hold_cnt=1.
//   OWNx, no req -> no gnt, go to IDLE, hold_cnt=0.
//   Whenever ownership leaves x, rr_last=x.
//  Handshake: the requester keeps req/we/addr/wdata stable until it sees gnt.
//   A new request may be presented in the cycle after gnt (back-to-back allowed, zero bubbles).
//  Simultaneous read grant and pending rvalid on the same port: the new capture overwrites rdata.
//   rvalid stays high for consecutive reads.
//  The rvalid/rdata of one port never change because of the other port's accesses.
//  hold_cnt width = clog2(MAX_HOLD+1); no wrap (saturates).
//  Throughput: 1 access/cycle total; worst-case wait for a requesting port = MAX_HOLD cycles.
// TESTING
//  1. After rst, only m0 reads addr 5 (mem[5]=0xA5) -> m0_gnt same cycle; next cycle m0_rvalid=1, m0_rdata=0xA5; owner=01.
//  2. m0 and m1 both req from IDLE after reset -> m0 gnt first; m0 keeps gnt 4 cycles, then m1 gnt; owner 01->10.
//  3. m1 writes 0x1234 to addr 9, then m0 reads addr 9 -> m0_rdata=0x1234; mem_write high exactly 1 cycle.
//  4. m0 continuous reqs, m1 idle for 10 cycles -> m0_gnt all 10 cycles (no forced switch); m1 req appears -> m1 gnt within <=4 cycles.
//  5. rst asserted in the same cycle as an m1 read grant -> next cycle m1_rvalid=0, m1_rdata=0, owner=00, no mem_write.
//  6. No reqs for 3 cycles -> mem_read=mem_write=0, all gnt=0, owner=00, hold_cnt=0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory.
// m0 is the core load/store port and m1 is the debug/loader port.
// Arbitration is round-robin with a bounded hold, so a busy port cannot starve the other.
module dmem_arbiter #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic [1:0]        owner
);

    localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_nxt;
    logic              rr_last;      // 0: m0 owned last, 1: m1 owned last
    logic              rr_nxt;
    logic              gnt0;
    logic              gnt1;

    // Saturating increment of the hold counter for a retained owner.
    logic [HOLD_W-1:0] hold_inc;
    assign hold_inc = (hold_cnt < HOLD_MAX) ? (hold_cnt + HOLD_ONE) : HOLD_MAX;

    // State, hold counter and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            hold_cnt <= '0;
            rr_last  <= 1'b1;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            rr_last  <= rr_nxt;
        end
    end

    // Next-state and grant decision.
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        rr_nxt    = rr_last;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        unique case (state)
            IDLE: begin
                if (m0_req && (!m1_req || rr_last)) begin
                    gnt0      = 1'b1;
                    state_nxt = OWN0;
                    hold_nxt  = HOLD_ONE;
                end else if (m1_req) begin
                    gnt1      = 1'b1;
                    state_nxt = OWN1;
                    hold_nxt  = HOLD_ONE;
                end
            end
            OWN0: begin
                if (m0_req && (!m1_req || (hold_cnt < HOLD_MAX))) begin
                    gnt0     = 1'b1;
                    hold_nxt = hold_inc;
                end else if (m1_req) begin
                    gnt1      = 1'b1;
                    state_nxt = OWN1;
                    hold_nxt  = HOLD_ONE;
                    rr_nxt    = 1'b0;
                end else begin
                    state_nxt = IDLE;
                    hold_nxt  = '0;
                    rr_nxt    = 1'b0;
                end
            end
            OWN1: begin
                if (m1_req && (!m0_req || (hold_cnt < HOLD_MAX))) begin
                    gnt1     = 1'b1;
                    hold_nxt = hold_inc;
                end else if (m0_req) begin
                    gnt0      = 1'b1;
                    state_nxt = OWN0;
                    hold_nxt  = HOLD_ONE;
                    rr_nxt    = 1'b1;
                end else begin
                    state_nxt = IDLE;
                    hold_nxt  = '0;
                    rr_nxt    = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                hold_nxt  = '0;
            end
        endcase
    end

    // Memory-side mux: the granted port drives the memory, otherwise all zero.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt0) begin
            mem_read  = ~m0_we;
            mem_write = m0_we;
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
        end else if (gnt1) begin
            mem_read  = ~m1_we;
            mem_write = m1_we;
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
        end
    end

    // Read responses: capture on the grant edge, pulse rvalid the cycle after.
    always_ff @(posedge clk) begin
        if (rst) begin
            m0_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rvalid <= 1'b0;
            m1_rdata  <= '0;
        end else begin
            m0_rvalid <= gnt0 & ~m0_we;
            m1_rvalid <= gnt1 & ~m1_we;
            if (gnt0 && !m0_we) begin
                m0_rdata <= mem_rdata;
            end
            if (gnt1 && !m1_we) begin
                m1_rdata <= mem_rdata;
            end
        end
    end

    assign m0_gnt = gnt0;
    assign m1_gnt = gnt1;
    assign owner  = state;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter with a small behavioural data memory.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  owner;

    logic [31:0] mem [0:15];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_HOLD(4)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .owner(owner)
    );

    // Behavioural memory: combinational read, write on the grant edge.
    assign mem_rdata = mem[mem_addr[3:0]];
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[3:0]] <= mem_wdata;
    end

    task automatic idle_inputs();
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
    endtask

    // Enters and leaves at a falling edge.
    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (owner !== 2'b00) begin failures++; $display("FAIL reset_owner got=%b exp=00", owner); end
        checks++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin failures++; $display("FAIL reset_rvalid got=%b exp=00", {m0_rvalid, m1_rvalid}); end
        checks++; if (m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h/%h exp=0/0", m0_rdata, m1_rdata); end
        checks++; if ({m0_gnt, m1_gnt, mem_read, mem_write} !== 4'b0) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", {m0_gnt, m1_gnt, mem_read, mem_write}); end
        @(negedge clk);
    endtask

    task automatic test_single_read();
        do_reset();
        m0_req = 1; m0_we = 0; m0_addr = 32'd5;
        #1;
        checks++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin failures++; $display("FAIL single_gnt got=%b%b exp=10", m0_gnt, m1_gnt); end
        checks++; if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 32'd5) begin failures++; $display("FAIL single_mem got=%b%b %h exp=10 5", mem_read, mem_write, mem_addr); end
        @(negedge clk);
        m0_req = 0;
        #1;
        checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hA5) begin failures++; $display("FAIL single_rdata got=%b %h exp=1 a5", m0_rvalid, m0_rdata); end
        checks++; if (owner !== 2'b01) begin failures++; $display("FAIL single_owner got=%b exp=01", owner); end
        checks++; if (m1_rvalid !== 1'b0) begin failures++; $display("FAIL single_m1_rvalid got=%b exp=0", m1_rvalid); end
        @(negedge clk);
        #1;
        checks++; if (m0_rvalid !== 1'b0 || m0_rdata !== 32'hA5 || owner !== 2'b00) begin failures++; $display("FAIL single_after got=%b %h %b exp=0 a5 00", m0_rvalid, m0_rdata, owner); end
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        logic [8:0] exp_m1;
        logic [1:0] exp_own;
        exp_m1 = 9'b011110000;
        do_reset();
        m0_req = 1; m0_addr = 32'd1;
        m1_req = 1; m1_addr = 32'd2;
        for (int i = 0; i < 9; i++) begin
            #1;
            exp_own = (i == 0) ? 2'b00 : ((i <= 4) ? 2'b01 : 2'b10);
            checks++; if (m1_gnt !== exp_m1[i] || m0_gnt !== ~exp_m1[i]) begin failures++; $display("FAIL rr_gnt cycle=%0d got=%b%b exp_m1=%b", i, m0_gnt, m1_gnt, exp_m1[i]); end
            checks++; if (owner !== exp_own) begin failures++; $display("FAIL rr_owner cycle=%0d got=%b exp=%b", i, owner, exp_own); end
            @(negedge clk);
        end
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_write_read();
        int wr_cycles;
        wr_cycles = 0;
        do_reset();
        m1_req = 1; m1_we = 1; m1_addr = 32'd9; m1_wdata = 32'h1234;
        #1;
        if (mem_write) wr_cycles++;
        checks++; if (m1_gnt !== 1'b1 || mem_wdata !== 32'h1234 || mem_addr !== 32'd9) begin failures++; $display("FAIL wr_issue got=%b %h %h exp=1 1234 9", m1_gnt, mem_wdata, mem_addr); end
        @(negedge clk);
        m1_req = 0; m1_we = 0;
        m0_req = 1; m0_we = 0; m0_addr = 32'd9;
        #1;
        if (mem_write) wr_cycles++;
        checks++; if (m0_gnt !== 1'b1 || mem_read !== 1'b1) begin failures++; $display("FAIL wr_rd_gnt got=%b%b exp=11", m0_gnt, mem_read); end
        checks++; if (m1_rvalid !== 1'b0) begin failures++; $display("FAIL wr_no_rvalid got=%b exp=0", m1_rvalid); end
        @(negedge clk);
        m0_req = 0;
        #1;
        if (mem_write) wr_cycles++;
        checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h1234) begin failures++; $display("FAIL wr_rd_data got=%b %h exp=1 1234", m0_rvalid, m0_rdata); end
        @(negedge clk);
        #1;
        if (mem_write) wr_cycles++;
        checks++; if (wr_cycles !== 1) begin failures++; $display("FAIL wr_once got=%0d exp=1", wr_cycles); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        do_reset();
        m1_req = 1; m1_addr = 32'd3;
        @(negedge clk);
        m1_req = 0;
        m0_req = 1; m0_addr = 32'd1;
        @(negedge clk);
        m0_addr = 32'd2;
        #1;
        checks++; if (m0_gnt !== 1'b1 || m0_rvalid !== 1'b1 || m0_rdata !== 32'h11) begin failures++; $display("FAIL b2b_first got=%b %b %h exp=1 1 11", m0_gnt, m0_rvalid, m0_rdata); end
        @(negedge clk);
        m0_req = 0;
        #1;
        checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h22) begin failures++; $display("FAIL b2b_second got=%b %h exp=1 22", m0_rvalid, m0_rdata); end
        checks++; if (m1_rvalid !== 1'b0 || m1_rdata !== 32'h33) begin failures++; $display("FAIL b2b_m1_held got=%b %h exp=0 33", m1_rvalid, m1_rdata); end
        @(negedge clk);
        #1;
        checks++; if (m0_rvalid !== 1'b0 || m0_rdata !== 32'h22) begin failures++; $display("FAIL b2b_end got=%b %h exp=0 22", m0_rvalid, m0_rdata); end
        @(negedge clk);
    endtask

    task automatic test_no_starve();
        int wait_cycles;
        do_reset();
        m0_req = 1; m0_addr = 32'd4;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++; if (m0_gnt !== 1'b1) begin failures++; $display("FAIL starve_m0 cycle=%0d got=%b exp=1", i, m0_gnt); end
            @(negedge clk);
        end
        m1_req = 1; m1_addr = 32'd6;
        wait_cycles = 0;
        #1;
        while (m1_gnt !== 1'b1 && wait_cycles < 8) begin
            @(negedge clk);
            wait_cycles++;
            #1;
        end
        checks++; if (wait_cycles !== 0) begin failures++; $display("FAIL starve_m1_wait got=%0d exp=0", wait_cycles); end
        @(negedge clk);
        m1_req = 0;
        #1;
        checks++; if (owner !== 2'b10 || m0_gnt !== 1'b1) begin failures++; $display("FAIL starve_return got=%b %b exp=10 1", owner, m0_gnt); end
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        do_reset();
        m1_req = 1; m1_addr = 32'd3;
        @(negedge clk);
        m1_req = 0;
        @(negedge clk);
        m1_req = 1; m1_addr = 32'd5;
        #1;
        checks++; if (m1_gnt !== 1'b1 || m1_rdata !== 32'h33) begin failures++; $display("FAIL abort_pre got=%b %h exp=1 33", m1_gnt, m1_rdata); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m1_req = 0;
        #1;
        checks++; if (m1_rvalid !== 1'b0 || m1_rdata !== 32'h0) begin failures++; $display("FAIL abort_rdata got=%b %h exp=0 0", m1_rvalid, m1_rdata); end
        checks++; if (owner !== 2'b00 || mem_write !== 1'b0) begin failures++; $display("FAIL abort_state got=%b %b exp=00 0", owner, mem_write); end
        @(negedge clk);
    endtask

    task automatic test_idle();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checks++; if ({mem_read, mem_write, m0_gnt, m1_gnt} !== 4'b0 || owner !== 2'b00) begin failures++; $display("FAIL idle cycle=%0d got=%b %b exp=0000 00", i, {mem_read, mem_write, m0_gnt, m1_gnt}, owner); end
            checks++; if (dut.hold_cnt !== 3'd0 || mem_addr !== 32'h0) begin failures++; $display("FAIL idle_hold cycle=%0d got=%0d %h exp=0 0", i, dut.hold_cnt, mem_addr); end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[1] = 32'h11;
        mem[2] = 32'h22;
        mem[3] = 32'h33;
        mem[5] = 32'hA5;
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_read();
        test_back_to_back();
        test_no_starve();
        test_reset_abort();
        test_idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
